// File: rtl/wb_pwm_ctrl.sv
// wb_pwm_ctrl: Wishbone classic slave driving three PWM outputs.
// Registers: CTRL, PERIOD, PRESCALE, DUTY0..2 and STATUS (live counter
// plus sticky WRAP flag). Unmapped accesses answer with wb_err.
// Optional macro PWM_SHADOW_EN: PERIOD/DUTYn writes are double-buffered
// and reach the counter/comparators only at a wrap or while disabled.
module wb_pwm_ctrl #(
    parameter int CNT_W = 16,
    parameter int PRE_W = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [14:0] wb_adr,
    input  logic [31:0] wb_dat_w,
    output logic [31:0] wb_dat_r,
    input  logic [3:0]  wb_sel,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    output logic        wb_ack,
    output logic        wb_err,
    output logic [2:0]  pwm
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PERIOD   = 3'd1;
    localparam logic [2:0] OFF_PRESCALE = 3'd2;
    localparam logic [2:0] OFF_DUTY0    = 3'd3;
    localparam logic [2:0] OFF_DUTY1    = 3'd4;
    localparam logic [2:0] OFF_DUTY2    = 3'd5;
    localparam logic [2:0] OFF_STATUS   = 3'd6;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    // bus handshake state
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [31:0]           dat_r_q, dat_r_d;

    // software-visible registers
    logic                  en_q, en_d;
    logic [2:0]            chen_q, chen_d;
    logic [2:0]            inv_q, inv_d;
    logic [CNT_W-1:0]      period_q, period_d;
    logic [PRE_W-1:0]      prescale_q, prescale_d;
    logic [2:0][CNT_W-1:0] duty_q, duty_d;
    logic                  wrap_q, wrap_d;

    // timebase and outputs
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            pwm_q, pwm_d;

    // values actually seen by the wrap compare and the comparators
    logic [CNT_W-1:0]      period_act;
    logic [2:0][CNT_W-1:0] duty_act;

    logic                  req, hit, wr_en, rd_en, wrap_clr;
    logic                  tick, wrap_evt;
    logic [31:0]           bmask, reg_view, wr_val;
    logic                  unused_wr;

    // Address decode, register read view and byte-lane merge for writes.
    always_comb begin
        // A request is only taken when no response is in flight, so a
        // strobe held through the ack cycle is not answered twice.
        req   = wb_cyc & wb_stb & ~ack_q & ~err_q;
        hit   = (wb_adr[14:3] == 12'd0) && (wb_adr[2:0] != 3'd7);
        wr_en = req & hit & wb_we;
        rd_en = req & hit & ~wb_we;
        bmask = '0;
        for (int i = 0; i < 4; i++) begin
            bmask[8*i +: 8] = {8{wb_sel[i]}};
        end
        reg_view = '0;
        case (wb_adr[2:0])
            OFF_CTRL:     reg_view = {21'd0, inv_q, 1'b0, chen_q, 3'd0, en_q};
            OFF_PERIOD:   reg_view[CNT_W-1:0] = period_q;
            OFF_PRESCALE: reg_view[PRE_W-1:0] = prescale_q;
            OFF_DUTY0:    reg_view[CNT_W-1:0] = duty_q[0];
            OFF_DUTY1:    reg_view[CNT_W-1:0] = duty_q[1];
            OFF_DUTY2:    reg_view[CNT_W-1:0] = duty_q[2];
            OFF_STATUS: begin
                reg_view[CNT_W-1:0] = cnt_q;
                reg_view[31]        = wrap_q;
            end
            default:      reg_view = '0;
        endcase
        // unselected lanes keep the current contents; bits beyond a
        // register's width are dropped when sliced below
        wr_val   = (reg_view & ~bmask) | (wb_dat_w & bmask);
        ack_d    = req & hit;
        err_d    = req & ~hit;
        dat_r_d  = rd_en ? reg_view : 32'd0;
        wrap_clr = wr_en && (wb_adr[2:0] == OFF_STATUS) && wb_sel[3] && wb_dat_w[31];
    end

    assign unused_wr = ^wr_val;

    // Register file next-state from bus writes.
    always_comb begin
        en_d       = en_q;
        chen_d     = chen_q;
        inv_d      = inv_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        duty_d     = duty_q;
        if (wr_en) begin
            case (wb_adr[2:0])
                OFF_CTRL: begin
                    en_d   = wr_val[0];
                    chen_d = wr_val[6:4];
                    inv_d  = wr_val[10:8];
                end
                OFF_PERIOD:   period_d   = wr_val[CNT_W-1:0];
                OFF_PRESCALE: prescale_d = wr_val[PRE_W-1:0];
                OFF_DUTY0:    duty_d[0]  = wr_val[CNT_W-1:0];
                OFF_DUTY1:    duty_d[1]  = wr_val[CNT_W-1:0];
                OFF_DUTY2:    duty_d[2]  = wr_val[CNT_W-1:0];
                default:      ;
            endcase
        end
    end

    // Prescaler, period counter and sticky WRAP flag.
    always_comb begin
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        tick     = 1'b0;
        wrap_evt = 1'b0;
        if (!en_q) begin
            pre_d = '0;
            cnt_d = '0;
        end else begin
            // >= so a PRESCALE lowered under the running prescaler ticks
            // at once instead of rolling the prescaler over its full range
            tick  = (pre_q >= prescale_q);
            pre_d = tick ? '0 : pre_q + PRE_ONE;
            if (tick) begin
                // >= also covers a PERIOD lowered below the live count
                if (cnt_q >= period_act) begin
                    cnt_d    = '0;
                    wrap_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end
        wrap_d = wrap_q;
        if (wrap_clr) wrap_d = 1'b0;
        // hardware set overrides a same-cycle software clear
        if (wrap_evt) wrap_d = 1'b1;
    end

`ifdef PWM_SHADOW_EN
    logic [CNT_W-1:0]      period_act_q, period_act_d;
    logic [2:0][CNT_W-1:0] duty_act_q, duty_act_d;

    // Active copies follow the bus registers only at a wrap or while disabled.
    always_comb begin
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        if (!en_q || wrap_evt) begin
            period_act_d = period_q;
            duty_act_d   = duty_q;
        end
    end

    // Active register storage.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            period_act_q <= '1;
            duty_act_q   <= '0;
        end else begin
            period_act_q <= period_act_d;
            duty_act_q   <= duty_act_d;
        end
    end

    assign period_act = period_act_q;
    assign duty_act   = duty_act_q;
`else
    assign period_act = period_q;
    assign duty_act   = duty_q;
`endif

    // Per-channel compare, invert and gating; registered below.
    always_comb begin
        pwm_d = '0;
        for (int n = 0; n < 3; n++) begin
            pwm_d[n] = en_q & chen_q[n] & ((cnt_q < duty_act[n]) ^ inv_q[n]);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_r_q    <= '0;
            en_q       <= 1'b0;
            chen_q     <= '0;
            inv_q      <= '0;
            period_q   <= '1;
            prescale_q <= '0;
            duty_q     <= '0;
            wrap_q     <= 1'b0;
            pre_q      <= '0;
            cnt_q      <= '0;
            pwm_q      <= '0;
        end else begin
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_r_q    <= dat_r_d;
            en_q       <= en_d;
            chen_q     <= chen_d;
            inv_q      <= inv_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            duty_q     <= duty_d;
            wrap_q     <= wrap_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
        end
    end

    assign wb_ack   = ack_q;
    assign wb_err   = err_q;
    assign wb_dat_r = dat_r_q;
    assign pwm      = pwm_q;

endmodule

// File: tb/tb_wb_pwm_ctrl.sv
// tb_wb_pwm_ctrl: randomized bench for wb_pwm_ctrl. The reference model
// holds the register contents and predicts the counter arithmetically
// from the enable edge: cnt(k) = (k / (PRESCALE+1)) mod (PERIOD+1).
module tb_wb_pwm_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [14:0] wb_adr = '0;
    logic [31:0] wb_dat_w = '0;
    logic [31:0] wb_dat_r;
    logic [3:0]  wb_sel = '0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic        wb_ack;
    logic        wb_err;
    logic [2:0]  pwm;

    wb_pwm_ctrl #(.CNT_W(16), .PRE_W(8)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wb_adr    (wb_adr),
        .wb_dat_w  (wb_dat_w),
        .wb_dat_r  (wb_dat_r),
        .wb_sel    (wb_sel),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err),
        .pwm       (pwm)
    );

    always #5 sys_clk = ~sys_clk;

    // posedge count; read at a negedge it names the edge just taken
    int cyc_n = 0;
    always @(posedge sys_clk) cyc_n <= cyc_n + 1;

    int total = 0;
    int bad = 0;
    int last_edge = 0;
    int edge_en = 0;
    logic [31:0] mreg [0:5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [31:0] width_mask(input int off);
        case (off)
            0:       return 32'h0000_0771;
            2:       return 32'h0000_00FF;
            default: return 32'h0000_FFFF;
        endcase
    endfunction

    task automatic model_reset();
        mreg[0] = 32'h0;
        mreg[1] = 32'h0000_FFFF;
        for (int i = 2; i < 6; i++) mreg[i] = 32'h0;
    endtask

    // pwm seen at negedge c comes from the counter of cycle c-1
    function automatic logic [2:0] exp_pwm(input int c, input int d0);
        int k, n, p, cv, du;
        logic [2:0] r;
        r = '0;
        k = c - 1 - edge_en;
        if (k < 0 || !mreg[0][0]) return r;
        n  = int'(mreg[1]);
        p  = int'(mreg[2]);
        cv = (k / (p + 1)) % (n + 1);
        for (int i = 0; i < 3; i++) begin
            du = (i == 0) ? d0 : int'(mreg[3+i]);
            if (mreg[0][4+i]) r[i] = (cv < du) ^ mreg[0][8+i];
        end
        return r;
    endfunction

    task automatic bus(input logic we, input logic [14:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic exp_err, output logic [31:0] rdat);
        @(negedge sys_clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
        @(negedge sys_clk);
        chk("ack", 32'(wb_ack), 32'(!exp_err));
        chk("err", 32'(wb_err), 32'(exp_err));
        rdat = wb_dat_r;
        if (exp_err) chk("err_rdata", wb_dat_r, 32'h0);
        last_edge = cyc_n;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge sys_clk);
        chk("resp_one_cycle", {30'd0, wb_ack, wb_err}, 32'h0);
        chk("rdata_idle", wb_dat_r, 32'h0);
    endtask

    task automatic wr(input int off, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d;
        bus(1'b1, 15'(off), dat, sel, 1'b0, d);
        if (off <= 5)
            mreg[off] = ((mreg[off] & ~lane_mask(sel)) | (dat & lane_mask(sel))) & width_mask(off);
    endtask

    task automatic rd_chk(input string tag, input int off, input logic [31:0] exp);
        logic [31:0] d;
        bus(1'b0, 15'(off), 32'h0, 4'hF, 1'b0, d);
        chk(tag, d, exp);
    endtask

    task automatic observe(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge sys_clk);
            chk(tag, 32'(pwm), 32'(exp_pwm(cyc_n, int'(mreg[3]))));
        end
    endtask

    task automatic run_cfg(input int n, input int p, input int d0, input int d1, input int d2,
                           input logic [31:0] ctrl, input int obs);
        wr(0, 32'h0, 4'hF);
        wr(6, 32'h8000_0000, 4'h8);
        wr(1, 32'(n), 4'hF);
        wr(2, 32'(p), 4'hF);
        wr(3, 32'(d0), 4'hF);
        wr(4, 32'(d1), 4'hF);
        wr(5, 32'(d2), 4'hF);
        wr(0, ctrl, 4'hF);
        edge_en = last_edge;
        observe(obs, "pwm");
    endtask

    // STATUS is captured at the ack edge from the preceding cycle's state
    task automatic chk_status(input string tag);
        logic [31:0] got, exp;
        int k, n, p, ticks;
        bus(1'b0, 15'd6, 32'h0, 4'hF, 1'b0, got);
        n     = int'(mreg[1]);
        p     = int'(mreg[2]);
        k     = last_edge - 1 - edge_en;
        ticks = k / (p + 1);
        exp   = 32'((k / (p + 1)) % (n + 1));
        if (ticks >= n + 1) exp[31] = 1'b1;
        chk(tag, got, exp);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, dat;
        logic [3:0]  sel;
        int off, n, p, guard, k, k_w, d0, hi;
        logic [31:0] ctrl;

        model_reset();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_ack", 32'(wb_ack), 32'h0);
        chk("rst_err", 32'(wb_err), 32'h0);
        chk("rst_rdata", wb_dat_r, 32'h0);
        chk("rst_pwm", 32'(pwm), 32'h0);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 6; i++) rd_chk("reset_reg", i, (i < 6) ? mreg[i] : 32'h0);
        rd_chk("reset_status", 6, 32'h0);

        // byte lane 1 only: data byte 0x56 lands in PERIOD[15:8]
        wr(1, 32'h1234_5678, 4'b0010);
        rd_chk("period_lane1", 1, mreg[1]);

        // unmapped accesses: offset 7 and any nonzero upper address bits
        bus(1'b0, 15'd7, 32'h0, 4'hF, 1'b1, d);
        bus(1'b1, 15'd7, 32'hFFFF_FFFF, 4'hF, 1'b1, d);
        bus(1'b1, 15'h008, 32'h0000_0771, 4'hF, 1'b1, d);
        bus(1'b0, 15'h00A, 32'h0, 4'hF, 1'b1, d);
        for (int i = 0; i < 6; i++) rd_chk("err_no_effect", i, mreg[i]);

        // random register traffic with random byte enables, kept disabled
        for (int i = 0; i < 16; i++) begin
            off = $urandom_range(0, 5);
            dat = $urandom;
            sel = 4'($urandom);
            if (off == 0) dat[0] = 1'b0;
            wr(off, dat, sel);
            rd_chk("rand_reg", off, mreg[off]);
        end

        // basic waveform: 3 high / 7 low every 10 cycles
        run_cfg(9, 0, 3, 0, 0, 32'h11, 30);
        chk_status("status_basic");

        // constant-high cases: DUTY1=0 inverted, DUTY2>PERIOD
        run_cfg(9, 0, 3, 0, 20, 32'h61, 15);
        wr(0, 32'h261, 4'hF);
        observe(20, "pwm_inv");
        chk("const_high", 32'(pwm[2:1]), 32'h3);

        // random configurations
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(0, 11);
            p = $urandom_range(0, 3);
            ctrl = 32'h1 | ($urandom & 32'h770);
            run_cfg(n, p, $urandom_range(0, n + 2), $urandom_range(0, n + 2),
                    $urandom_range(0, n + 2), ctrl, 60);
            chk_status("status_rand");
        end

        // clearing WRAP while disabled leaves STATUS at zero
        wr(0, 32'h0, 4'hF);
        wr(6, 32'h8000_0000, 4'h8);
        rd_chk("status_clear", 6, 32'h0);

        // DUTY0 change in mid-period
        run_cfg(99, 0, 50, 0, 0, 32'h11, 0);
        guard = 0;
        while (((cyc_n - edge_en) % 100) != 29 && guard < 200) begin
            @(negedge sys_clk);
            guard++;
        end
        chk("sync_bound", 32'(guard < 200), 32'h1);
        wr(3, 32'd10, 4'hF);
        k_w = last_edge - edge_en;
        hi = 0;
        for (int i = 0; i < 230; i++) begin
            @(negedge sys_clk);
            k = cyc_n - 1 - edge_en;
`ifdef PWM_SHADOW_EN
            d0 = ((k / 100) == (k_w / 100)) ? 50 : 10;
`else
            d0 = 10;
`endif
            chk("duty_update", 32'(pwm), 32'(exp_pwm(cyc_n, d0)));
            if ((k / 100) == (k_w / 100) + 1 && pwm[0]) hi++;
        end
        chk("next_period_high", 32'(hi), 32'd10);

        // reset in the middle of a write: no response, write dropped
        @(negedge sys_clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = 15'd0; wb_dat_w = 32'h0000_0771; wb_sel = 4'hF;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        chk("rst_mid_resp", {30'd0, wb_ack, wb_err}, 32'h0);
        chk("rst_mid_pwm", 32'(pwm), 32'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) rd_chk("rst_mid_reg", i, mreg[i]);
        rd_chk("rst_mid_status", 6, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
